// File: rtl/bus_master.sv
// Single-outstanding initiator for the request/acknowledge register bus.
// Accepts a command, drives the bus until ack or timeout, then returns a response.
module bus_master #(
  parameter int CMD_W   = 1,
  parameter int AW      = 12,
  parameter int DW      = 32,
  parameter int SW      = 4,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iCmdValid,
  output logic             oCmdReady,
  input  logic [CMD_W-1:0] iCmd,
  input  logic [AW-1:0]    iAddr,
  input  logic [SW-1:0]    iSel,
  input  logic [DW-1:0]    iWData,
  output logic             oRspValid,
  input  logic             iRspReady,
  output logic [DW-1:0]    oRspData,
  output logic             oRspErr,
  output logic             oMstReq,
  output logic [CMD_W-1:0] oMstCmd,
  output logic [AW-1:0]    oMstAddr,
  output logic [SW-1:0]    oMstSel,
  output logic [DW-1:0]    oMstWData,
  input  logic             iMstAck,
  input  logic [DW-1:0]    iMstRData,
  output logic [CNT_W-1:0] oTxnCnt,
  output logic [CNT_W-1:0] oErrCnt
);

  // A zero TIMEOUT still needs a legal (1-bit) counter even though it is unused.
  localparam int WCW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int WLASTI = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [WCW-1:0] WLAST = WLASTI[WCW-1:0];
  localparam logic [CMD_W-1:0] CMD_RD = CMD_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RSP} state_t;

  state_t           state_q;
  logic [WCW-1:0]   wait_q;
  logic             req_q, rspv_q, err_q;
  logic [CMD_W-1:0] cmd_q;
  logic [AW-1:0]    addr_q;
  logic [SW-1:0]    sel_q;
  logic [DW-1:0]    wdata_q, rdata_q, rdata_d;
  logic [CNT_W-1:0] txn_q, errc_q;

  // Unselected lanes (and all lanes on a write) read as zero, so X from the slave never leaks.
  for (genvar i = 0; i < SW; i++) begin : g_lane
    assign rdata_d[i*8 +: 8] = (sel_q[i] && cmd_q == CMD_RD) ? iMstRData[i*8 +: 8] : 8'h00;
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      req_q   <= 1'b0;
      rspv_q  <= 1'b0;
      err_q   <= 1'b0;
      cmd_q   <= '0;
      addr_q  <= '0;
      sel_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      txn_q   <= '0;
      errc_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (iCmdValid) begin
            cmd_q   <= iCmd;
            addr_q  <= iAddr;
            sel_q   <= iSel;
            wdata_q <= iWData;
            wait_q  <= '0;
            req_q   <= 1'b1;
            state_q <= S_BUS;
          end
        end
        S_BUS: begin
          // Ack is checked first so an ack on the timeout edge still succeeds.
          if (iMstAck) begin
            rdata_q <= rdata_d;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            rspv_q  <= 1'b1;
            state_q <= S_RSP;
          end else if (TIMEOUT != 0 && wait_q == WLAST) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            req_q   <= 1'b0;
            rspv_q  <= 1'b1;
            state_q <= S_RSP;
          end else if (wait_q != '1) begin
            wait_q <= wait_q + 1'b1;
          end
        end
        S_RSP: begin
          if (iRspReady) begin
            rspv_q  <= 1'b0;
            state_q <= S_IDLE;
            if (err_q) begin
              if (errc_q != '1) errc_q <= errc_q + 1'b1;
            end else begin
              if (txn_q != '1) txn_q <= txn_q + 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign oCmdReady = (state_q == S_IDLE);
  assign oMstReq   = req_q;
  assign oMstCmd   = cmd_q;
  assign oMstAddr  = addr_q;
  assign oMstSel   = sel_q;
  assign oMstWData = wdata_q;
  assign oRspValid = rspv_q;
  assign oRspData  = rdata_q;
  assign oRspErr   = err_q;
  assign oTxnCnt   = txn_q;
  assign oErrCnt   = errc_q;

endmodule
